// File: rtl/mux3_rr_sequencer_if.sv
// rtl/mux3_rr_sequencer_if.sv - request/data/select bundle between sources, sequencer and 3:1 mux checker
interface mux3_rr_sequencer_if #(
  parameter int WIDTH = 1
);
  logic             en;
  logic [2:0]       req;
  logic [WIDTH-1:0] D0;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic             Sel1;
  logic             Sel0;
  logic [2:0]       grant;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;

  modport master (
    output en, req, D0, D1, D2,
    input  Sel1, Sel0, grant, dout, dout_valid
  );

  modport slave (
    input  en, req, D0, D1, D2,
    output Sel1, Sel0, grant, dout, dout_valid
  );
endinterface

// File: rtl/mux3_rr_sequencer.sv
// rtl/mux3_rr_sequencer.sv - round-robin 3:1 mux select sequencer with dwell limit and registered data
module mux3_rr_sequencer #(
  parameter int WIDTH = 1,
  parameter int DWELL = 4
) (
  input logic                  clk,
  input logic                  rst,
  mux3_rr_sequencer_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] DWELL_RELOAD = 8'(DWELL - 1);
  localparam logic [1:0] SEL_NONE     = 2'b11;

  state_t           state, next_state;
  logic [1:0]       cur, next_cur;
  logic [1:0]       last, next_last;
  logic [7:0]       dwell_cnt, next_dwell;
  logic [1:0]       sel, next_sel;
  logic [2:0]       grant, next_grant;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;

  logic [2:0]       cur_onehot;
  logic [2:0]       others;
  logic [2:0]       pick_src;
  logic [1:0]       pick_idx;

  // First asserted request scanning from the source after 'from', wrapping; 3 means none.
  function automatic logic [1:0] rr_pick(input logic [1:0] from, input logic [2:0] r);
    logic [1:0] o1, o2;
    o1 = (from == 2'd2) ? 2'd0 : from + 2'd1;
    o2 = (o1 == 2'd2) ? 2'd0 : o1 + 2'd1;
    if (r[o1])        return o1;
    else if (r[o2])   return o2;
    else if (r[from]) return from;
    else              return 2'd3;
  endfunction

  assign cur_onehot = 3'b001 << cur;
  assign others     = bus.req & ~cur_onehot;
  // In GRANT last==cur, so scanning 'others' from last gives the next source in rotation.
  assign pick_src   = (state == IDLE) ? bus.req : others;
  assign pick_idx   = rr_pick(last, pick_src);

  // Next-state, grant and select decision.
  always_comb begin
    logic do_pick;
    logic go_idle;
    do_pick    = 1'b0;
    go_idle    = 1'b0;
    next_state = state;
    next_cur   = cur;
    next_last  = last;
    next_dwell = dwell_cnt;
    next_sel   = sel;
    next_grant = grant;

    case (state)
      IDLE: begin
        if (bus.en && |bus.req) do_pick = 1'b1;
        else                    go_idle = 1'b1;
      end
      GRANT: begin
        if (!bus.en) begin
          go_idle = 1'b1;
        end else if (!bus.req[cur]) begin
          if (|others) do_pick = 1'b1;
          else         go_idle = 1'b1;
        end else if (dwell_cnt == 8'd0) begin
          if (|others) do_pick = 1'b1;
          else         next_dwell = DWELL_RELOAD;
        end else begin
          next_dwell = dwell_cnt - 8'd1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (do_pick) begin
      next_state = GRANT;
      next_cur   = pick_idx;
      next_last  = pick_idx;
      next_sel   = pick_idx;
      next_grant = 3'b001 << pick_idx;
      next_dwell = DWELL_RELOAD;
    end else if (go_idle) begin
      next_state = IDLE;
      next_sel   = SEL_NONE;
      next_grant = 3'b000;
    end
  end

  // Arbitration state, select and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= 2'd0;
      last      <= 2'd2;
      dwell_cnt <= 8'd0;
      sel       <= SEL_NONE;
      grant     <= 3'b000;
    end else begin
      state     <= next_state;
      cur       <= next_cur;
      last      <= next_last;
      dwell_cnt <= next_dwell;
      sel       <= next_sel;
      grant     <= next_grant;
    end
  end

  // Mirror of the downstream 3:1 mux, one cycle behind the registered select.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (sel)
        2'd0:    dout <= bus.D0;
        2'd1:    dout <= bus.D1;
        2'd2:    dout <= bus.D2;
        default: dout <= '0;
      endcase
      dout_valid <= (sel != SEL_NONE);
    end
  end

  assign bus.Sel1       = sel[1];
  assign bus.Sel0       = sel[0];
  assign bus.grant      = grant;
  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;

endmodule

// File: tb/tb_mux3_rr_sequencer.sv
// tb/tb_mux3_rr_sequencer.sv - scoreboard bench for mux3_rr_sequencer with directed vectors
module tb_mux3_rr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux3_rr_sequencer_if #(.WIDTH(1)) bus ();

  mux3_rr_sequencer #(.WIDTH(1), .DWELL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] grant;
    logic [1:0] sel;
    logic       dout;
    logic       valid;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] prev_sel = 2'b11;

  function automatic logic [1:0] sel_of(input logic [2:0] g);
    case (g)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Apply one cycle of inputs and queue the outputs expected after the following edge.
  task automatic step(input logic r, input logic e, input logic [2:0] rq,
                      input logic [2:0] d, input logic [2:0] eg, input string tag);
    exp_t x;
    @(negedge clk);
    rst     = r;
    bus.en  = e;
    bus.req = rq;
    bus.D0  = d[0];
    bus.D1  = d[1];
    bus.D2  = d[2];
    @(posedge clk);
    x.tag   = tag;
    x.grant = r ? 3'b000 : eg;
    x.sel   = sel_of(x.grant);
    x.valid = !r && (prev_sel != 2'd3);
    x.dout  = x.valid ? d[prev_sel] : 1'b0;
    sb.push_back(x);
    prev_sel = x.sel;
  endtask

  // Monitor: pop one expectation per presented output cycle and compare every field.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      n_cmp++;
      if (bus.grant !== x.grant) begin
        n_bad++;
        $display("FAIL %s grant: got %b want %b", x.tag, bus.grant, x.grant);
      end
      n_cmp++;
      if ({bus.Sel1, bus.Sel0} !== x.sel) begin
        n_bad++;
        $display("FAIL %s sel: got %b want %b", x.tag, {bus.Sel1, bus.Sel0}, x.sel);
      end
      n_cmp++;
      if (bus.dout !== x.dout) begin
        n_bad++;
        $display("FAIL %s dout: got %b want %b", x.tag, bus.dout, x.dout);
      end
      n_cmp++;
      if (bus.dout_valid !== x.valid) begin
        n_bad++;
        $display("FAIL %s dout_valid: got %b want %b", x.tag, bus.dout_valid, x.valid);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en  = 1'b1;
    bus.req = 3'b111;
    bus.D0  = 1'b0;
    bus.D1  = 1'b0;
    bus.D2  = 1'b0;

    // reset held with all requests pending
    repeat (2) step(1, 1, 3'b111, 3'b110, 3'b000, "reset");

    // full rotation, DWELL=4 per source
    repeat (4) step(0, 1, 3'b111, 3'b110, 3'b001, "rot_s0");
    repeat (4) step(0, 1, 3'b111, 3'b110, 3'b010, "rot_s1");
    repeat (4) step(0, 1, 3'b111, 3'b110, 3'b100, "rot_s2");
    repeat (4) step(0, 1, 3'b111, 3'b011, 3'b001, "rot_s0b");

    // early release of source 1 on its second cycle
    step(0, 1, 3'b111, 3'b101, 3'b010, "early_g1a");
    step(0, 1, 3'b111, 3'b010, 3'b010, "early_g1b");
    step(0, 1, 3'b101, 3'b111, 3'b100, "early_rel");
    step(0, 1, 3'b101, 3'b000, 3'b100, "early_hold");

    // single requester across repeated dwell reloads
    for (int i = 0; i < 10; i++)
      step(0, 1, 3'b010, (i % 2 == 0) ? 3'b010 : 3'b101, 3'b010, "single");

    // enable drop mid-grant, then resume from last+1
    step(0, 1, 3'b111, 3'b010, 3'b010, "pre_en");
    step(0, 0, 3'b111, 3'b010, 3'b000, "en_off1");
    step(0, 0, 3'b111, 3'b111, 3'b000, "en_off2");
    step(0, 1, 3'b111, 3'b100, 3'b100, "en_resume");
    step(0, 1, 3'b111, 3'b100, 3'b100, "s2_hold");

    // reset during source-2 grant, pointer restarts at source 0
    step(1, 1, 3'b111, 3'b111, 3'b000, "mid_rst");
    step(0, 1, 3'b111, 3'b001, 3'b001, "post_rst");
    step(0, 1, 3'b111, 3'b001, 3'b001, "post_rst2");

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux3_rr_sequencer.md
# mux3_rr_sequencer

Round-robin select sequencer placed directly upstream of the 3:1 mux. It arbitrates among three requesting sources, drives the mux select pair (`Sel1`, `Sel0`) with a bounded dwell time per grant, and registers the selected data word for the next stage. It produces the select stimulus that the 3:1 mux consumes, and it mirrors that mux's data path internally so the registered output can be checked against the mux output.

## Interface
- `WIDTH`, 1: width of each data input and of `dout`.
- `DWELL`, 4: maximum consecutive cycles one source holds the grant while others wait; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  sequencer enable; low forces idle.
- `req`  in  3  request per source; bit i requests `D{i}`.
- `D0`, `D1`, `D2`  in  WIDTH each  source data words.
- `Sel1`, `Sel0`  out  1 each  registered mux select; {Sel1,Sel0} = 00→D0, 01→D1, 10→D2, 11→none.
- `grant`  out  3  registered one-hot grant; all zero when idle.
- `dout`  out  WIDTH  registered selected data.
- `dout_valid`  out  1  `dout` holds data from a granted source.

## Operation
- State: `IDLE`, `GRANT`; `cur` (index 0..2), `last` (index of most recent grant), and an 8-bit `dwell_cnt`.
- Reset values: state `IDLE`, {Sel1,Sel0}=11, `grant`=000, `dout`=0, `dout_valid`=0, `last`=2 (so source 0 has first priority), `dwell_cnt`=0.
- Round-robin pick: the first asserted `req` bit in order last+1, last+2, last+3 (mod 3). A pick always updates `last` and `cur`, sets `grant`=onehot(cur), sets select=cur, and loads `dwell_cnt`=DWELL-1.
- `IDLE` behaviour:
  - `en`=1 and |req → pick, then go to `GRANT`.
  - Otherwise stay; select=11, `grant`=000.
- `GRANT` behaviour, in priority order:
  1. `en`=0 → `IDLE`, select=11, `grant`=000.
  2. `req[cur]`=0 → if any other request is asserted, pick immediately (no idle bubble); else go to `IDLE`.
  3. `dwell_cnt`=0 → if any other request is asserted, pick the next one in round-robin order; else re-grant `cur` and reload `dwell_cnt`=DWELL-1.
  4. Otherwise decrement `dwell_cnt`; grant is unchanged.
- Data path, every cycle:
  - `dout` ← D[sel] if the registered select ≠ 11, else 0.
  - `dout_valid` ← (registered select ≠ 11).
- Select value 11 is never paired with a nonzero `grant`. `grant` and select always encode the same source.
- `rst` takes precedence over all inputs. Reset asserted mid-grant returns every output to its reset value on that edge. The round-robin pointer restarts at source 0.

## Timing
- Request-to-grant latency: `req` sampled at edge n → `grant` and select valid after edge n.
- Select-to-data latency: one cycle. `dout`/`dout_valid` after edge n+1 reflect the select registered at edge n. Total request-to-data latency is 2 edges.
- Dwell: with continuous competing requests, each source holds the grant for exactly DWELL cycles. With DWELL=1 the grant rotates every cycle.
- A request dropped at edge n releases the grant at edge n. There is no wrap or overflow beyond `dwell_cnt`, which reloads at 0.
- Simultaneous request drop and dwell expiry: rule 2 applies; the result is the same rotation.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `req`=111 and `en`=1 → {Sel1,Sel0}=11, `grant`=000, `dout`=0, `dout_valid`=0. After release, the first grant is source 0 (`grant`=001).
- Rotation with DWELL=4: `req`=111, `en`=1, D0=0, D1=1, D2=1 (WIDTH=1) → grant sequence 001×4, 010×4, 100×4, 001…. `dout` follows D of the granted source one cycle later.
- Early release: grant on source 1, drop `req[1]` at cycle 2 with `req`=101 → next edge `grant`=100, select=10, no idle cycle.
- Single requester: `req`=010 held for 10 cycles → `grant`=010 continuously and select=01 steady through repeated dwell reloads. `dout_valid`=1 from the second edge onward.
- Enable drop: mid-grant, set `en`=0 → next edge select=11 and `grant`=000. One edge later `dout`=0 and `dout_valid`=0. With `en`=1 restored, round-robin resumes from `last`+1.
- Mid-operation reset: assert `rst` during the source-2 grant → all outputs return to reset values on that edge. After release, the first grant is source 0.
